i2c_write_master: RTL and testbench
===================================

// Module: i2c_write_master
// PURPOSE
//  Bit-level I2C master for the audio-codec configuration path. Takes one 24-bit
//  write word {slave_addr[7:0], reg_addr[6:0], reg_data[8:0]} plus a GO level
//  from the codec config sequencer. Emits START, three bytes MSB-first with
//  ACK slots, and STOP on SCLK/SDAT, then reports DONE and per-byte ACK status.
//  Runs in the 10 kHz clk_i2c domain.
// PARAMETERS
//  Q_CYCLES   1   clk_i2c cycles per SCL quarter-period (>=1); SCL = f_clk/(4*Q_CYCLES)
// PORTS
//  clk_i2c    in     1   I2C controller work clock
//  reset_n    in     1   asynchronous reset, active-low
//  i2c_data   in    24   {slave addr+W, sub-addr, data} word; latched on accepted go
//  go         in     1   start request, level; held high by sequencer until done
//  done       out    1   transaction finished; held while go stays high
//  busy       out    1   high from go acceptance until done rises
//  ack        out    3   NACK flags: [2]=byte0, [1]=byte1, [0]=byte2; 0 = slave ACKed
//  i2c_sclk   out    1   SCL, push-pull, idle high
//  i2c_sdat   inout  1   SDA, open-drain: drives 0 or Z only, never 1
// BEHAVIOUR
//  - Reset (async, any time incl. mid-byte): state IDLE, i2c_sclk=1, i2c_sdat=Z,
//    done=0, busy=0, ack=3'b000, quarter counter=0, shift reg=0.
//  - States: IDLE -> START -> BIT (27 slots: 3 bytes x (8 data + 1 ack)) -> STOP -> DONE.
//  - IDLE: go=1 sampled at edge E0 -> latch i2c_data, clear ack, busy=1, go START.
//    go while busy or in DONE is not a new request; i2c_data changes after E0 ignored.
//  - Quarter tick every Q_CYCLES clocks; all SCL/SDA changes occur on ticks.
//  - START (2 quarters): q0 SDA=0,SCL=1; q1 SCL=0.
//  - Each bit slot (4 quarters): q0 SCL=0, SDA set (data bit, or Z for ack slot);
//    q1 SCL=1; q2 SCL=1, ack slot samples i2c_sdat (1 -> set NACK flag); q3 SCL=0.
//  - Data bits MSB-first: i2c_data[23] first, i2c_data[0] last. SDA changes only
//    while SCL low.
//  - NACK does not abort: all three bytes and STOP are still sent; flag recorded.
//  - STOP (3 quarters): q0 SCL=0,SDA=0; q1 SCL=1,SDA=0; q2 SCL=1,SDA=Z.
//  - Total 2+108+3 = 113 quarters: done rises and busy falls at edge E0+113*Q_CYCLES.
//  - DONE: done=1, ack stable, bus idle, while go=1. go=0 -> done=0 next edge, IDLE.
//    New go accepted at earliest on the edge after done clears.
//  - ack valid from done rise until next go acceptance.
//  - Reset mid-transfer may leave slave mid-byte; recovery is the sequencer's job.
// STRUCTURE
//  - Shared package i2c_pkg: state encoding (IDLE/START/BIT/STOP/DONE),
//    START_Q=2, BIT_Q=4, STOP_Q=3, NUM_SLOTS=27, WM8731 address constant 8'h34.
//  - One natural sub-module: i2c_qtick (Q_CYCLES down-counter -> 1-cycle tick).
//  - Main FSM, 5-bit slot counter, 2-bit quarter counter, 24-bit shift reg inline.
// TESTING
//  1 go=1, i2c_data=24'h34_0E_01, slave model ACKs all -> bytes 34,0E,01 decoded,
//    START/STOP legal, ack=3'b000, done at E0+113 (Q_CYCLES=1).
//  2 Slave NACKs byte1 only -> ack=3'b010, byte2 still sent, STOP issued, done=1.
//  3 Hold go 20 cycles after done -> done stays 1, no SCL edges; go=0 -> done=0
//    next edge; go=1 with 24'h34_04_16 -> second clean transaction.
//  4 Change i2c_data and toggle go during busy -> bus bits match latched word,
//    single transaction only.
//  5 Assert reset_n=0 mid byte1 -> same-cycle i2c_sclk=1, i2c_sdat=Z, done=0,
//    busy=0, ack=0; after release, go starts fresh from START.
//  6 Q_CYCLES=3 -> every SCL level lasts multiples of 3 clks, done at E0+339.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write master: FSM states, phase lengths, slot helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BIT   = 3'd2,
      ST_STOP  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Quarter-periods spent in each bus phase
   localparam int START_Q   = 2;
   localparam int BIT_Q     = 4;
   localparam int STOP_Q    = 3;
   // 3 bytes x (8 data bits + 1 ack slot)
   localparam int NUM_SLOTS = 27;

   // WM8731 codec slave address with the write bit
   localparam logic [7:0] WM8731_ADDR = 8'h34;

   // NACK flag bit owned by an ack slot; zero for data slots
   function automatic logic [2:0] nack_flag(input logic [4:0] slot);
      logic [2:0] f;
      f = 3'b000;
      if (slot == 5'd8)  f = 3'b100;
      if (slot == 5'd17) f = 3'b010;
      if (slot == 5'd26) f = 3'b001;
      return f;
   endfunction

   function automatic logic is_ack_slot(input logic [4:0] slot);
      return |nack_flag(slot);
   endfunction

endpackage

// File: rtl/i2c_write_master_if.sv
// Sequencer-side handshake and SCL output of the I2C write master.
// Latency: n/a (wiring only).
// Backpressure: go is a level held by the sequencer until done; no other flow control.
interface i2c_write_master_if;
   logic [23:0] i2c_data;
   logic        go;
   logic        done;
   logic        busy;
   logic [2:0]  ack;
   logic        i2c_sclk;

   modport master (
      input  i2c_data, go,
      output done, busy, ack, i2c_sclk
   );

   modport slave (
      output i2c_data, go,
      input  done, busy, ack, i2c_sclk
   );
endinterface

// File: rtl/i2c_qtick.sv
// Quarter-period timebase: one-cycle tick every Q_CYCLES clocks while running.
// Latency: first tick Q_CYCLES clocks after clr_i drops.
// Backpressure: none; clr_i holds the counter at its reload value.
module i2c_qtick #(
   parameter int Q_CYCLES = 1
) (
   input  logic clk_i2c,
   input  logic reset_n,
   input  logic clr_i,
   output logic tick_o
);

   localparam int            CW     = (Q_CYCLES > 1) ? $clog2(Q_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(Q_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Down-count to zero, reload on the tick or while held clear
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || (cnt_q == '0)) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = !clr_i && (cnt_q == '0);

endmodule

// File: rtl/i2c_write_master.sv
// Bit-level I2C master: START, three bytes MSB-first with ack slots, STOP, then DONE.
// Latency: done rises 113*Q_CYCLES clocks after the edge that accepts go.
// Backpressure: go is ignored while busy or in DONE; done holds until go drops.
module i2c_write_master
   import i2c_pkg::*;
#(
   parameter int Q_CYCLES = 1
) (
   input  logic               clk_i2c,
   input  logic               reset_n,
   i2c_write_master_if.master bus,
   inout  wire                i2c_sdat
);

   state_e      state_q, state_d;
   logic [4:0]  slot_q, slot_d;
   logic [1:0]  qtr_q, qtr_d;
   logic [23:0] shreg_q, shreg_d;
   logic [2:0]  ack_q, ack_d;
   logic        sclk_q, sclk_d;
   logic        sda_low_q, sda_low_d;
   logic        running;
   logic        tick;

   assign running = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP);

   i2c_qtick #(.Q_CYCLES(Q_CYCLES)) u_qtick (
      .clk_i2c (clk_i2c),
      .reset_n (reset_n),
      .clr_i   (!running),
      .tick_o  (tick)
   );

   // Next bus position and the SCL/SDA levels that belong to it
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      qtr_d     = qtr_q;
      shreg_d   = shreg_q;
      ack_d     = ack_q;
      sclk_d    = sclk_q;
      sda_low_d = sda_low_q;

      case (state_q)
         ST_IDLE: begin
            sclk_d    = 1'b1;
            sda_low_d = 1'b0;
            if (bus.go) begin
               // Accepting edge is START quarter 0: SDA falls while SCL stays high
               state_d   = ST_START;
               qtr_d     = 2'd0;
               slot_d    = 5'd0;
               shreg_d   = bus.i2c_data;
               ack_d     = 3'b000;
               sda_low_d = 1'b1;
            end
         end

         ST_START: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (qtr_q == 2'(START_Q - 1)) begin
                  state_d   = ST_BIT;
                  qtr_d     = 2'd0;
                  slot_d    = 5'd0;
                  sda_low_d = ~shreg_q[23];
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end

         ST_BIT: begin
            if (tick) begin
               if (qtr_q == 2'(BIT_Q - 1)) begin
                  // Slot boundary: SCL already low, so SDA may move now
                  sclk_d = 1'b0;
                  qtr_d  = 2'd0;
                  if (slot_q == 5'(NUM_SLOTS - 1)) begin
                     state_d   = ST_STOP;
                     sda_low_d = 1'b1;
                  end else begin
                     slot_d = slot_q + 5'd1;
                     if (!is_ack_slot(slot_q)) begin
                        shreg_d = {shreg_q[22:0], 1'b0};
                     end
                     sda_low_d = is_ack_slot(slot_d) ? 1'b0 : ~shreg_d[23];
                  end
               end else begin
                  // q0->q1 and q1->q2 keep SCL high, q2->q3 drops it
                  qtr_d  = qtr_q + 2'd1;
                  sclk_d = (qtr_q != 2'd2);
                  // Sample the slave mid-high; a released line is a NACK
                  if ((qtr_q == 2'd1) && i2c_sdat) begin
                     ack_d = ack_q | nack_flag(slot_q);
                  end
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               sclk_d = 1'b1;
               if (qtr_q == 2'(STOP_Q - 1)) begin
                  state_d   = ST_DONE;
                  qtr_d     = 2'd0;
                  sda_low_d = 1'b0;
               end else begin
                  // SDA held low through q1, released at q2 (the STOP edge)
                  qtr_d     = qtr_q + 2'd1;
                  sda_low_d = (qtr_q == 2'd0);
               end
            end
         end

         ST_DONE: begin
            sclk_d    = 1'b1;
            sda_low_d = 1'b0;
            if (!bus.go) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered bus drivers
   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         slot_q    <= 5'd0;
         qtr_q     <= 2'd0;
         shreg_q   <= 24'd0;
         ack_q     <= 3'b000;
         sclk_q    <= 1'b1;
         sda_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         qtr_q     <= qtr_d;
         shreg_q   <= shreg_d;
         ack_q     <= ack_d;
         sclk_q    <= sclk_d;
         sda_low_q <= sda_low_d;
      end
   end

   assign bus.done     = (state_q == ST_DONE);
   assign bus.busy     = running;
   assign bus.ack      = ack_q;
   assign bus.i2c_sclk = sclk_q;
   // Open-drain: pull low or release, never drive high
   assign i2c_sdat     = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
module tb_i2c_write_master;
   import i2c_pkg::*;

   logic clk_i2c = 1'b0;
   logic reset_n;
   always #5 clk_i2c = ~clk_i2c;

   i2c_write_master_if if1();
   i2c_write_master_if if3();
   wire sda1;
   wire sda3;
   pullup (sda1);
   pullup (sda3);

   logic sel;
   logic slave_pull;
   assign sda1 = (!sel && slave_pull) ? 1'b0 : 1'bz;
   assign sda3 = (sel && slave_pull) ? 1'b0 : 1'bz;

   i2c_write_master #(.Q_CYCLES(1)) dut (
      .clk_i2c (clk_i2c), .reset_n (reset_n), .bus (if1.master), .i2c_sdat (sda1));
   i2c_write_master #(.Q_CYCLES(3)) dut3 (
      .clk_i2c (clk_i2c), .reset_n (reset_n), .bus (if3.master), .i2c_sdat (sda3));

   // Slave/bus monitor on the selected instance
   wire mon_scl = sel ? if3.i2c_sclk : if1.i2c_sclk;
   wire mon_sda = sel ? sda3 : sda1;
   logic       mon_clr;
   logic [2:0] nack_mask;
   logic [7:0] got[$];
   int         start_cnt, stop_cnt, rise_cnt, len_bad, run_len;
   logic [3:0] bitcnt;
   logic [1:0] bytecnt;
   logic       prev_scl, prev_sda, skip_fall, first_len;
   logic [7:0] sh;

   logic [7:0] exp_bytes[$];
   logic [2:0] exp_ack[$];
   int total = 0;
   int bad = 0;

   initial begin
      forever begin
         @(negedge clk_i2c);
         if (!reset_n || mon_clr) begin
            got.delete();
            start_cnt = 0; stop_cnt = 0; rise_cnt = 0; len_bad = 0; run_len = 0;
            bitcnt = 4'd0; bytecnt = 2'd0; sh = 8'h00;
            slave_pull = 1'b0; skip_fall = 1'b0; first_len = 1'b1;
            prev_scl = mon_scl; prev_sda = mon_sda;
         end else begin
            if (mon_scl && prev_scl && prev_sda && !mon_sda) begin
               start_cnt++; bitcnt = 4'd0; bytecnt = 2'd0; skip_fall = 1'b1;
            end
            if (mon_scl && prev_scl && !prev_sda && mon_sda) stop_cnt++;
            if (mon_scl != prev_scl) begin
               if (!first_len && ((run_len % (sel ? 3 : 1)) != 0)) len_bad++;
               first_len = 1'b0;
               run_len = 1;
               if (mon_scl) begin
                  rise_cnt++;
                  if (bitcnt < 4'd8) sh = {sh[6:0], mon_sda};
               end else if (skip_fall) begin
                  skip_fall = 1'b0;
               end else if (bitcnt == 4'd8) begin
                  slave_pull = 1'b0; bitcnt = 4'd0; bytecnt = bytecnt + 2'd1;
               end else begin
                  bitcnt = bitcnt + 4'd1;
                  if (bitcnt == 4'd8) begin
                     got.push_back(sh);
                     slave_pull = (bytecnt != 2'd3) ? !nack_mask[2'd2 - bytecnt] : 1'b0;
                  end
               end
            end else begin
               run_len++;
            end
            prev_scl = mon_scl;
            prev_sda = mon_sda;
         end
      end
   end

   task automatic step();
      @(posedge clk_i2c);
      #1;
   endtask

   task automatic set_go(input logic v);
      if (sel) if3.go = v; else if1.go = v;
   endtask

   task automatic set_data(input logic [23:0] d);
      if (sel) if3.i2c_data = d; else if1.i2c_data = d;
   endtask

   function automatic logic cur_done();
      return sel ? if3.done : if1.done;
   endfunction

   function automatic logic cur_busy();
      return sel ? if3.busy : if1.busy;
   endfunction

   function automatic logic [2:0] cur_ack();
      return sel ? if3.ack : if1.ack;
   endfunction

   // Runs one transaction; cyc counts posedges from the accepting edge up to done
   task automatic do_txn(input logic [23:0] data, input logic [2:0] nack,
                         input int disturb_at, output int cyc, output logic busy1);
      set_go(1'b0); step(); step();
      nack_mask = nack; mon_clr = 1'b1; step(); mon_clr = 1'b0;
      exp_bytes.push_back(data[23:16]);
      exp_bytes.push_back(data[15:8]);
      exp_bytes.push_back(data[7:0]);
      exp_ack.push_back(nack);
      set_data(data); set_go(1'b1);
      cyc = 0; busy1 = 1'b0;
      while (!cur_done() && cyc < 3000) begin
         step(); cyc++;
         if (cyc == 1) busy1 = cur_busy();
         if (disturb_at != 0 && cyc == disturb_at) begin set_data(~data); set_go(1'b0); end
         if (disturb_at != 0 && cyc == disturb_at + 5) set_go(1'b1);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) step();
      total++; if (if1.i2c_sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b exp=1", if1.i2c_sclk); end
      total++; if (sda1 !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda1); end
      total++; if (if1.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", if1.done); end
      total++; if (if1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", if1.busy); end
      total++; if (if1.ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", if1.ack); end
      total++; if (if3.i2c_sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk3 got=%b exp=1", if3.i2c_sclk); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int cyc; logic b1; logic [7:0] e, g;
      sel = 1'b0;
      do_txn({WM8731_ADDR, 16'h0E01}, 3'b000, 0, cyc, b1);
      total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", b1); end
      total++; if (cyc - 1 != 113) begin bad++; $display("FAIL basic_latency got=%0d exp=113", cyc - 1); end
      total++; if (got.size() != 3) begin bad++; $display("FAIL basic_nbytes got=%0d exp=3", got.size()); end
      for (int i = 0; i < 3; i++) begin
         e = exp_bytes.pop_front();
         g = (got.size() > i) ? got[i] : 8'h00;
         total++; if (g !== e) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, g, e); end
      end
      e = {5'd0, exp_ack.pop_front()};
      total++; if (cur_ack() !== e[2:0]) begin bad++; $display("FAIL basic_ack got=%b exp=%b", cur_ack(), e[2:0]); end
      total++; if (start_cnt != 1 || stop_cnt != 1) begin bad++; $display("FAIL basic_startstop got=%0d/%0d exp=1/1", start_cnt, stop_cnt); end
      total++; if (rise_cnt != 28) begin bad++; $display("FAIL basic_sclrises got=%0d exp=28", rise_cnt); end
      total++; if (cur_busy() !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", cur_busy()); end
   endtask

   task automatic test_hold();
      int cyc; int r; logic b1; logic [7:0] e, g;
      r = rise_cnt;
      repeat (20) step();
      total++; if (if1.done !== 1'b1) begin bad++; $display("FAIL hold_done got=%b exp=1", if1.done); end
      total++; if (rise_cnt != r || if1.i2c_sclk !== 1'b1) begin bad++; $display("FAIL hold_idle got=%0d rises exp=%0d", rise_cnt, r); end
      set_go(1'b0);
      step();
      total++; if (if1.done !== 1'b0) begin bad++; $display("FAIL hold_done_clear got=%b exp=0", if1.done); end
      do_txn(24'h34_04_16, 3'b000, 0, cyc, b1);
      total++; if (cyc - 1 != 113) begin bad++; $display("FAIL second_latency got=%0d exp=113", cyc - 1); end
      for (int i = 0; i < 3; i++) begin
         e = exp_bytes.pop_front();
         g = (got.size() > i) ? got[i] : 8'h00;
         total++; if (g !== e) begin bad++; $display("FAIL second_byte%0d got=%h exp=%h", i, g, e); end
      end
      e = {5'd0, exp_ack.pop_front()};
      total++; if (if1.ack !== e[2:0]) begin bad++; $display("FAIL second_ack got=%b exp=%b", if1.ack, e[2:0]); end
   endtask

   task automatic test_nack();
      int cyc; logic b1; logic [7:0] e, g;
      do_txn(24'h34_12_AB, 3'b010, 0, cyc, b1);
      e = {5'd0, exp_ack.pop_front()};
      total++; if (if1.ack !== e[2:0]) begin bad++; $display("FAIL nack_ack got=%b exp=%b", if1.ack, e[2:0]); end
      for (int i = 0; i < 3; i++) begin
         e = exp_bytes.pop_front();
         g = (got.size() > i) ? got[i] : 8'h00;
         total++; if (g !== e) begin bad++; $display("FAIL nack_byte%0d got=%h exp=%h", i, g, e); end
      end
      total++; if (stop_cnt != 1 || if1.done !== 1'b1) begin bad++; $display("FAIL nack_stop got=%0d done=%b exp=1 done=1", stop_cnt, if1.done); end
   endtask

   task automatic test_disturb();
      int cyc; logic b1; logic [7:0] e, g;
      do_txn(24'h34_1C_5A, 3'b000, 30, cyc, b1);
      total++; if (cyc - 1 != 113) begin bad++; $display("FAIL disturb_latency got=%0d exp=113", cyc - 1); end
      for (int i = 0; i < 3; i++) begin
         e = exp_bytes.pop_front();
         g = (got.size() > i) ? got[i] : 8'h00;
         total++; if (g !== e) begin bad++; $display("FAIL disturb_byte%0d got=%h exp=%h", i, g, e); end
      end
      void'(exp_ack.pop_front());
      repeat (5) step();
      total++; if (start_cnt != 1 || if1.done !== 1'b1) begin bad++; $display("FAIL disturb_single got=%0d starts done=%b exp=1", start_cnt, if1.done); end
   endtask

   task automatic test_reset_mid();
      int cyc; logic b1; logic [7:0] e, g;
      set_go(1'b0); step(); step();
      nack_mask = 3'b100; mon_clr = 1'b1; step(); mon_clr = 1'b0;
      set_data(24'h34_55_AA); set_go(1'b1);
      repeat (60) step();
      total++; if (if1.ack !== 3'b100) begin bad++; $display("FAIL midrst_preack got=%b exp=100", if1.ack); end
      reset_n = 1'b0; set_go(1'b0);
      #1;
      total++; if (if1.i2c_sclk !== 1'b1 || sda1 !== 1'b1) begin bad++; $display("FAIL midrst_bus got=%b%b exp=11", if1.i2c_sclk, sda1); end
      total++; if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b exp=00", if1.done, if1.busy); end
      total++; if (if1.ack !== 3'b000) begin bad++; $display("FAIL midrst_ack got=%b exp=000", if1.ack); end
      step(); step();
      reset_n = 1'b1;
      do_txn(24'h34_22_33, 3'b000, 0, cyc, b1);
      total++; if (cyc - 1 != 113 || start_cnt != 1) begin bad++; $display("FAIL midrst_fresh got=%0d starts=%0d exp=113/1", cyc - 1, start_cnt); end
      for (int i = 0; i < 3; i++) begin
         e = exp_bytes.pop_front();
         g = (got.size() > i) ? got[i] : 8'h00;
         total++; if (g !== e) begin bad++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, g, e); end
      end
      void'(exp_ack.pop_front());
   endtask

   task automatic test_slow();
      int cyc; logic b1; logic [7:0] e, g;
      set_go(1'b0); step();
      sel = 1'b1;
      do_txn(24'h34_07_9C, 3'b001, 0, cyc, b1);
      total++; if (cyc - 1 != 339) begin bad++; $display("FAIL slow_latency got=%0d exp=339", cyc - 1); end
      total++; if (len_bad != 0) begin bad++; $display("FAIL slow_levels got=%0d bad lengths exp=0", len_bad); end
      total++; if (rise_cnt != 28) begin bad++; $display("FAIL slow_sclrises got=%0d exp=28", rise_cnt); end
      for (int i = 0; i < 3; i++) begin
         e = exp_bytes.pop_front();
         g = (got.size() > i) ? got[i] : 8'h00;
         total++; if (g !== e) begin bad++; $display("FAIL slow_byte%0d got=%h exp=%h", i, g, e); end
      end
      e = {5'd0, exp_ack.pop_front()};
      total++; if (if3.ack !== e[2:0]) begin bad++; $display("FAIL slow_ack got=%b exp=%b", if3.ack, e[2:0]); end
      set_go(1'b0); step();
   endtask

   initial begin
      sel = 1'b0; mon_clr = 1'b0; nack_mask = 3'b000;
      if1.go = 1'b0; if1.i2c_data = 24'd0;
      if3.go = 1'b0; if3.i2c_data = 24'd0;
      test_reset();
      test_basic();
      test_hold();
      test_nack();
      test_disturb();
      test_reset_mid();
      test_slow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
